tx_arbiter: RTL and testbench

Shares the single 7-bit serial transmitter among `N_REQ` requesters. It selects one pending requester, presents its 7-bit word to the transmitter and fires the transmitter's active-low start strobe. It then holds the word stable for a fixed frame time and pulses a per-requester acknowledge. It sits directly in front of the transmitter: `tx_start_n` drives its `start` input and `tx_data` drives its `data_in`.

---
 rtl/tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one 7-bit serial transmitter among N_REQ requesters.
// Picks a pending requester, launches its word with a one-cycle active-low
// start strobe, holds the word for FRAME_CYCLES and then pulses its ack.
// Build option TX_ARBITER_RR_EN: defined selects round-robin arbitration,
// undefined selects fixed priority (lowest asserted index wins).
module tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned FRAME_CYCLES = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   data_in,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 tx_start_n,
    output logic [6:0]           tx_data,
    output logic [15:0]          frames_sent
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W  = $clog2(FRAME_CYCLES);
    localparam int unsigned WORD_W = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]    ack_d, grant_d;
    logic                busy_d, tx_start_n_d;
    logic [WORD_W-1:0]   tx_data_d;
    logic [15:0]         frames_d;
    logic [IDX_W-1:0]    win_c;
    logic [WORD_W-1:0]   win_word_c;
    int unsigned         dist_c, best_c;
`ifdef TX_ARBITER_RR_EN
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
`endif

    // Winner selection: the requester closest to the search start wins
    always_comb begin
        win_c  = '0;
        dist_c = 0;
        best_c = N_REQ;
        for (int unsigned j = 0; j < N_REQ; j++) begin
`ifdef TX_ARBITER_RR_EN
            dist_c = (j >= 32'(ptr_q)) ? (j - 32'(ptr_q)) : (j + N_REQ - 32'(ptr_q));
`else
            dist_c = j;
`endif
            if (req[j] && (dist_c < best_c)) begin
                best_c = dist_c;
                win_c  = IDX_W'(j);
            end
        end
    end

    // Word of the current arbitration winner
    always_comb begin
        win_word_c = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (win_c == IDX_W'(j)) begin
                win_word_c = data_in[WORD_W*j +: WORD_W];
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ack_d        = ack;
        grant_d      = grant;
        busy_d       = busy;
        tx_start_n_d = tx_start_n;
        tx_data_d    = tx_data;
        frames_d     = frames_sent;
`ifdef TX_ARBITER_RR_EN
        ptr_d        = ptr_q;
        win_d        = win_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d      = N_REQ'(1) << win_c;
                    tx_data_d    = win_word_c;
                    busy_d       = 1'b1;
                    tx_start_n_d = 1'b0;
`ifdef TX_ARBITER_RR_EN
                    win_d        = win_c;
`endif
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start_n_d = 1'b1;
                cnt_d        = CNT_W'(FRAME_CYCLES - 1);
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    ack_d    = grant;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    frames_d = frames_sent + 16'd1;
`ifdef TX_ARBITER_RR_EN
                    ptr_d    = (win_q == IDX_W'(N_REQ - 1)) ? '0 : (win_q + IDX_W'(1));
`endif
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ack         <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            tx_start_n  <= 1'b1;
            tx_data     <= '0;
            frames_sent <= '0;
`ifdef TX_ARBITER_RR_EN
            ptr_q       <= '0;
            win_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack         <= ack_d;
            grant       <= grant_d;
            busy        <= busy_d;
            tx_start_n  <= tx_start_n_d;
            tx_data     <= tx_data_d;
            frames_sent <= frames_d;
`ifdef TX_ARBITER_RR_EN
            ptr_q       <= ptr_d;
            win_q       <= win_d;
`endif
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: randomized requesters against a frame-timeline reference
// model; expected frames are queued at arbitration and popped on ack.
`timescale 1ns/1ps
module tb_tx_arbiter;

    localparam int N = 4;
    localparam int F = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [6:0]      words [N];
    logic [7*N-1:0]  data_in;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            tx_start_n;
    logic [6:0]      tx_data;
    logic [15:0]     frames_sent;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [N-1:0] onehot;
        logic [6:0]   data;
        logic [15:0]  count;
    } exp_t;

    exp_t        sb_q [$];
    bit          m_active = 1'b0;
    int          m_phase  = 0;
    int          m_win    = 0;
    int          m_ptr    = 0;
    logic [6:0]  m_data   = '0;
    logic [15:0] m_frames = '0;
    bit          preload_pend = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) data_in[7*i +: 7] = words[i];
    end

    tx_arbiter #(.N_REQ(N), .FRAME_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .ack(ack), .grant(grant), .busy(busy), .tx_start_n(tx_start_n),
        .tx_data(tx_data), .frames_sent(frames_sent)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // First asserted request starting at ptr and ascending with wrap
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    // Reference model: one frame occupies F+3 edges from its latch edge
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0; m_phase = 0; m_win = 0; m_ptr = 0;
                m_data = '0; m_frames = '0;
                sb_q.delete();
            end else begin
                if (preload_pend) m_frames = 16'hFFFF;
                if (m_active) begin
                    m_phase++;
                    if (m_phase == F + 1) begin
                        m_frames = m_frames + 16'd1;
`ifdef TX_ARBITER_RR_EN
                        m_ptr = (m_win + 1) % N;
`endif
                    end
                    if (m_phase == F + 3) m_active = 1'b0;
                end
                if (!m_active && req != '0) begin
                    m_win    = pick(req, m_ptr);
                    m_data   = words[m_win];
                    m_active = 1'b1;
                    m_phase  = 0;
                    sb_q.push_back('{onehot: N'(1) << m_win, data: m_data,
                                     count: m_frames + 16'd1});
                end
            end
        end
    end

    // Monitor: per-cycle timeline checks plus scoreboard pop on every ack
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                logic         e_busy;
                logic [N-1:0] e_oh;
                exp_t         e;
                e_oh   = N'(1) << m_win;
                e_busy = m_active && (m_phase <= F);
                check("tx_start_n", 32'(tx_start_n), 32'(!(m_active && m_phase == 0)));
                check("busy", 32'(busy), 32'(e_busy));
                check("grant", 32'(grant), 32'(e_busy ? e_oh : '0));
                check("ack_timing", 32'(ack),
                      32'((m_active && m_phase == F + 1) ? e_oh : '0));
                check("tx_data", 32'(tx_data), 32'(m_data));
                check("frames_sent", 32'(frames_sent), 32'(m_frames));
                if (ack != '0) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_ack", 32'(ack), 32'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_ack", 32'(ack), 32'(e.onehot));
                        check("sb_data", 32'(tx_data), 32'(e.data));
                        check("sb_count", 32'(frames_sent), 32'(e.count));
                    end
                end
            end
        end
    end

    // One requester cycle: drop on ack, optionally raise, withdraw or disturb
    task automatic step(input bit rnd, input logic [N-1:0] persist);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (req[i] && ack[i]) begin
                req[i] = 1'b0;
            end else if (!req[i] && (persist[i] || (rnd && $urandom_range(0, 5) == 0))) begin
                words[i] = 7'($urandom);
                req[i]   = 1'b1;
            end else if (rnd && req[i] && m_active && i == m_win && m_phase >= 3 &&
                         m_phase <= F - 2 && $urandom_range(0, 9) == 0) begin
                words[i] = 7'($urandom);
                req[i]   = 1'b0;
            end else if (rnd && req[i] && !(m_active && i == m_win) &&
                         $urandom_range(0, 49) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((req != '0 || m_active) && k < 300) begin
            step(1'b0, '0);
            k++;
        end
        if (k >= 300) check("drain_timeout", 32'(k), 32'(0));
    endtask

    initial begin
        int k;
        for (int i = 0; i < N; i++) words[i] = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_start_n", 32'(tx_start_n), 32'(1));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_frames", 32'(frames_sent), 32'(0));
        rst = 1'b0;

        // single request from requester 1
        @(negedge clk);
        words[1] = 7'h55;
        req      = 4'b0010;
        repeat (F + 6) step(1'b0, '0);
        check("single_frames", 32'(frames_sent), 32'(1));
        check("single_data", 32'(tx_data), 32'(7'h55));

        // full contention, twice
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) words[i] = 7'($urandom);
            req = 4'b1111;
            drain();
        end

        // persistent 1010, then requester 1 stops asking
        repeat (3 * (F + 3)) step(1'b0, 4'b1010);
        repeat (2 * (F + 3)) step(1'b0, 4'b1000);
        drain();

        // randomized traffic
        repeat (1500) step(1'b1, '0);
        drain();

        // reset in the middle of a frame
        @(negedge clk);
        words[2] = 7'h2A;
        req      = 4'b0100;
        k = 0;
        while (!(m_active && m_phase == 6) && k < 40) begin
            step(1'b0, 4'b0100);
            k++;
        end
        if (k >= 40) check("midrst_timeout", 32'(k), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("midrst_start_n", 32'(tx_start_n), 32'(1));
        check("midrst_grant", 32'(grant), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_ack", 32'(ack), 32'(0));
        check("midrst_frames", 32'(frames_sent), 32'(0));
        check("midrst_tx_data", 32'(tx_data), 32'(0));
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (F + 6) step(1'b0, '0);

        // frames_sent wrap from 16'hFFFF
        drain();
        @(negedge clk);
        #2 force dut.frames_sent = 16'hFFFF;
        #1 release dut.frames_sent;
        preload_pend = 1'b1;
        @(posedge clk);
        #1 preload_pend = 1'b0;
        @(negedge clk);
        words[0] = 7'h11;
        req      = 4'b0001;
        repeat (F + 6) step(1'b0, '0);
        check("wrap_frames", 32'(frames_sent), 32'(0));
        drain();

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
